counter_seq_ctrl: RTL and testbench
===================================

// Module: counter_seq_ctrl
// PURPOSE
//  Command-driven sequencer for one 8-bit programmable counter: loads a start value, issues N count enables, opens a readout window on the counter's tri-state bus, and returns the sampled value.
//  Sits between a host command port (valid/ready) and the counter's load/en/data_in/out_en pins.
//  Checks the sampled bus value against start+N and flags a mismatch.
// PARAMETERS
//  WIDTH      8   counter/data width
//  STEP_W     16  width of step count (max 2^STEP_W-1 enables per run)
//  RD_CYCLES  2   readout window length in cycles (>=1); bus sampled on last cycle
// PORTS
//  clk        in   1        clock
//  rst        in   1        asynchronous reset, active-high
//  cmd_valid  in   1        command offered
//  cmd_ready  out  1        command accepted when cmd_valid&cmd_ready
//  cmd_start  in   WIDTH    value to load
//  cmd_steps  in   STEP_W   number of count enables to issue (0 allowed)
//  hold       in   1        pause counting (no enable issued while high)
//  abort      in   1        cancel current run, no response
//  cnt_load   out  1        to counter load
//  cnt_en     out  1        to counter en
//  cnt_data   out  WIDTH    to counter data_in
//  cnt_oe     out  1        to counter out_en
//  bus_in     in   WIDTH    counter tri-state output bus
//  rsp_valid  out  1        result available
//  rsp_ready  in   1        result consumed when rsp_valid&rsp_ready
//  rsp_data   out  WIDTH    sampled bus value
//  rsp_err    out  1        rsp_data != (cmd_start+cmd_steps) mod 2^WIDTH
//  busy       out  1        state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except cmd_ready=1; captured start/steps/expected cleared.
//  - All outputs are Moore decodes of registered state/counters; cnt_load and cnt_en are never both high.
//  - IDLE: cmd_ready=1. On handshake: capture start and steps; expected = start + steps[WIDTH-1:0] (wraps mod 2^WIDTH); go to LOAD.
//  - LOAD (1 cycle): cnt_load=1, cnt_data=start; remaining=steps. Next: COUNT if steps!=0, else READ.
//  - COUNT: cnt_en = !hold. Each cycle with cnt_en=1 decrements remaining. The cycle that issues the last enable (remaining==1) exits to READ.
//  - hold high in COUNT stretches the run by one cycle per held cycle; hold is ignored in all other states.
//  - READ: cnt_oe=1 for exactly RD_CYCLES cycles. On the last cycle, bus_in is registered into rsp_data and rsp_err is computed. Next: RESP.
//  - RESP: rsp_valid=1; rsp_data/rsp_err are held stable until rsp_ready; then IDLE. cmd_ready=0 here (no overlap).
//  - Latency (hold=0): handshake at cycle T -> cnt_load at T+1; cnt_en at T+2..T+1+N; cnt_oe at T+2+N..T+1+N+RD_CYCLES; rsp_valid from T+2+N+RD_CYCLES.
//  - abort in LOAD/COUNT/READ: next cycle state=IDLE; cnt_en/cnt_oe/cnt_load low; no rsp. Ignored in IDLE and RESP.
//  - abort and the final-step transition in the same cycle: abort wins.
//  - cmd_steps=0: no enables; expected=start.
//  - Max steps (all ones): remaining is never zero-extended incorrectly; exactly 2^STEP_W-1 enables are issued.
//  - rst mid-run: immediate return to reset values; counter pins drop asynchronously.
// CONFIGURATION
//  COUNTER_SEQ_REPEAT_EN defined: adds input cmd_repeat [3:0], captured at handshake.
//   After READ, if repeats_left != 0: decrement and go to LOAD with start = sampled bus value and the same steps; expected is recomputed from the new start.
//   rsp is issued only after the final pass; rsp_err is sticky across passes. cmd_repeat=0 -> single pass.
//  Not defined: no cmd_repeat port; READ always goes to RESP.
// STRUCTURE
//  counter_seq_pkg: state enum {IDLE,LOAD,COUNT,READ,RESP}; default WIDTH/STEP_W/RD_CYCLES localparams; function for the expected-value wrap.
//  Sub-module counter_seq_step_ctr: loadable down-counter with decrement enable and last-step flag.
//  Top holds the FSM, readout-window timer and response registers.
// TESTING
//  1. start=8'hF0, steps=5, hold=0, model counter -> 5 cnt_en pulses; rsp_data=8'hF5, rsp_err=0; rsp_valid at T+2+5+RD_CYCLES.
//  2. start=8'hFE, steps=3 -> wrap; rsp_data=8'h01, rsp_err=0.
//  3. steps=0, start=8'h5A -> cnt_load only, no cnt_en; rsp_data=8'h5A.
//  4. steps=4, hold high for 3 cycles mid-COUNT -> still exactly 4 enables; rsp_valid delayed 3 cycles.
//  5. abort on 2nd cnt_en cycle -> IDLE next cycle; no rsp_valid; cmd_ready=1.
//  6. Model counter stuck at +1 off, start=0, steps=2 -> rsp_data=8'h03, rsp_err=1. With COUNTER_SEQ_REPEAT_EN and repeat=2: final rsp_data=start+3*steps.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared types and defaults for the counter sequencer.
// Sequencer state encoding, default sizing, and the wrap-around helper
// used to compute the value the counter should read back.
package counter_seq_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_STEP_W    = 16;
    localparam int unsigned DEF_RD_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        COUNT = 3'd2,
        READ  = 3'd3,
        RESP  = 3'd4
    } state_e;

    // Sum of start and step count, truncated to w bits (the counter wraps).
    function automatic logic [31:0] wrap_add(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (a + b) & mask;
    endfunction

endpackage

// File: rtl/counter_seq_step_ctr.sv
// counter_seq_step_ctr: loadable down-counter of remaining count enables.
// Loaded with the full step count, decremented once per issued enable;
// last_o marks the cycle whose enable is the final one of the run.
module counter_seq_step_ctr #(
    parameter int unsigned STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [STEP_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic              last_o
);

    logic [STEP_W-1:0] remaining_q;

    // Remaining-steps register: load has priority, never decrements past zero.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            remaining_q <= '0;
        end else if (load_i) begin
            remaining_q <= load_val_i;
        end else if (dec_i && (remaining_q != '0)) begin
            remaining_q <= remaining_q - STEP_W'(1);
        end
    end

    assign last_o = (remaining_q == STEP_W'(1));

endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: command-driven sequencer for an 8-bit programmable counter.
// Loads a start value, issues N count enables, opens a readout window on the
// counter bus, samples it and reports the value plus a mismatch flag.
// Optional feature macro: COUNTER_SEQ_REPEAT_EN (adds cmd_repeat_i, chained passes).
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned STEP_W    = DEF_STEP_W,
    parameter int unsigned RD_CYCLES = DEF_RD_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [WIDTH-1:0]  cmd_start_i,
    input  logic [STEP_W-1:0] cmd_steps_i,
`ifdef COUNTER_SEQ_REPEAT_EN
    input  logic [3:0]        cmd_repeat_i,
`endif
    input  logic              hold_i,
    input  logic              abort_i,
    output logic              cnt_load_o,
    output logic              cnt_en_o,
    output logic [WIDTH-1:0]  cnt_data_o,
    output logic              cnt_oe_o,
    input  logic [WIDTH-1:0]  bus_in_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WIDTH-1:0]  rsp_data_o,
    output logic              rsp_err_o,
    output logic              busy_o
);

    localparam int unsigned      RD_W    = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;
    localparam logic [RD_W-1:0]  RD_LAST = RD_W'(RD_CYCLES - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  start_q, start_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [WIDTH-1:0]  expected_q, expected_d;
    logic [RD_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
`ifdef COUNTER_SEQ_REPEAT_EN
    logic [3:0]        repeats_q, repeats_d;
    logic              err_acc_q, err_acc_d;
`endif

    logic cmd_fire;
    logic en_issue;
    logic rd_last;
    logic step_last;
    logic mismatch;
    logic more_passes;

    assign cmd_fire = (state_q == IDLE) && cmd_valid_i;
    assign en_issue = (state_q == COUNT) && !hold_i;
    assign rd_last  = (state_q == READ) && (rd_cnt_q == RD_LAST);
    assign mismatch = (bus_in_i != expected_q);
`ifdef COUNTER_SEQ_REPEAT_EN
    assign more_passes = (repeats_q != 4'd0);
`else
    assign more_passes = 1'b0;
`endif

    counter_seq_step_ctr #(
        .STEP_W (STEP_W)
    ) u_step_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == LOAD),
        .load_val_i (steps_q),
        .dec_i      (en_issue),
        .last_o     (step_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort in an active state beats every other exit.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (cmd_valid_i) state_d = LOAD;
            LOAD: begin
                if (abort_i)                state_d = IDLE;
                else if (steps_q != '0)     state_d = COUNT;
                else                        state_d = READ;
            end
            COUNT: begin
                if (abort_i)                    state_d = IDLE;
                else if (en_issue && step_last) state_d = READ;
            end
            READ: begin
                if (abort_i)      state_d = IDLE;
                else if (rd_last) state_d = more_passes ? LOAD : RESP;
            end
            RESP:  if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore output decode (cnt_en additionally gated by hold while counting).
    always_comb begin
        cmd_ready_o = 1'b0;
        cnt_load_o  = 1'b0;
        cnt_data_o  = '0;
        cnt_oe_o    = 1'b0;
        rsp_valid_o = 1'b0;
        unique case (state_q)
            IDLE:  cmd_ready_o = 1'b1;
            LOAD: begin
                cnt_load_o = 1'b1;
                cnt_data_o = start_q;
            end
            READ:  cnt_oe_o    = 1'b1;
            RESP:  rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign cnt_en_o   = en_issue;
    assign busy_o     = (state_q != IDLE);
    assign rsp_data_o = rsp_data_q;
    assign rsp_err_o  = rsp_err_q;

    // Datapath next-state: command capture, readout timer, bus sampling.
    always_comb begin
        start_d    = start_q;
        steps_d    = steps_q;
        expected_d = expected_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        rd_cnt_d   = ((state_q == READ) && (state_d == READ)) ? rd_cnt_q + RD_W'(1) : '0;
`ifdef COUNTER_SEQ_REPEAT_EN
        repeats_d  = repeats_q;
        err_acc_d  = err_acc_q;
`endif
        if (cmd_fire) begin
            start_d    = cmd_start_i;
            steps_d    = cmd_steps_i;
            expected_d = WIDTH'(wrap_add(32'(cmd_start_i), 32'(cmd_steps_i[WIDTH-1:0]), WIDTH));
`ifdef COUNTER_SEQ_REPEAT_EN
            repeats_d  = cmd_repeat_i;
            err_acc_d  = 1'b0;
`endif
        end
        if (rd_last && !abort_i) begin
`ifdef COUNTER_SEQ_REPEAT_EN
            if (more_passes) begin
                // Chain: the sampled value seeds the next pass; the error is sticky.
                repeats_d  = repeats_q - 4'd1;
                start_d    = bus_in_i;
                expected_d = WIDTH'(wrap_add(32'(bus_in_i), 32'(steps_q[WIDTH-1:0]), WIDTH));
                err_acc_d  = err_acc_q | mismatch;
            end else begin
                rsp_data_d = bus_in_i;
                rsp_err_d  = err_acc_q | mismatch;
            end
`else
            rsp_data_d = bus_in_i;
            rsp_err_d  = mismatch;
`endif
        end
    end

    // Datapath registers; everything clears on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q    <= '0;
            steps_q    <= '0;
            expected_q <= '0;
            rd_cnt_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
`ifdef COUNTER_SEQ_REPEAT_EN
            repeats_q  <= '0;
            err_acc_q  <= 1'b0;
`endif
        end else begin
            start_q    <= start_d;
            steps_q    <= steps_d;
            expected_q <= expected_d;
            rd_cnt_q   <= rd_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
`ifdef COUNTER_SEQ_REPEAT_EN
            repeats_q  <= repeats_d;
            err_acc_q  <= err_acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: self-checking bench for counter_seq_ctrl.
// A behavioural counter (with an optional fixed read offset) sits on the
// pins; expected responses are queued at command time and popped at rsp_valid.
module tb_counter_seq_ctrl;

    localparam int W  = 8;
    localparam int SW = 16;
    localparam int RD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_start;
    logic [SW-1:0] cmd_steps;
    logic [3:0]    cmd_repeat_v;
    logic          hold;
    logic          abort;
    logic          cnt_load;
    logic          cnt_en;
    logic [W-1:0]  cnt_data;
    logic          cnt_oe;
    logic [W-1:0]  bus_in;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_err;
    logic          busy;

    logic [W-1:0]  model_q = '0;
    logic [W-1:0]  fault_off = '0;
    int            cyc = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural counter attached to the sequencer pins.
    always @(posedge clk) begin
        if (cnt_load)    model_q <= cnt_data;
        else if (cnt_en) model_q <= model_q + 8'd1;
    end
    assign bus_in = cnt_oe ? (model_q + fault_off) : '0;

    counter_seq_ctrl #(
        .WIDTH     (W),
        .STEP_W    (SW),
        .RD_CYCLES (RD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_start_i (cmd_start),
        .cmd_steps_i (cmd_steps),
`ifdef COUNTER_SEQ_REPEAT_EN
        .cmd_repeat_i(cmd_repeat_v),
`endif
        .hold_i      (hold),
        .abort_i     (abort),
        .cnt_load_o  (cnt_load),
        .cnt_en_o    (cnt_en),
        .cnt_data_o  (cnt_data),
        .cnt_oe_o    (cnt_oe),
        .bus_in_i    (bus_in),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy)
    );

    // Issue one command and follow it to its response (or to its abort).
    task automatic run_cmd(input string name, input logic [W-1:0] start,
                           input logic [SW-1:0] steps, input logic [3:0] rpt,
                           input int hold_at, input int hold_len, input int abort_at);
        int   hs, n_en, n_ld, n_oe, both, lat, limit, passes;
        bit   got;
        exp_t e;
        logic [W-1:0] v;
        logic         err;

        passes = int'(rpt) + 1;
        @(negedge clk);
        cmd_start = start; cmd_steps = steps; cmd_repeat_v = rpt; cmd_valid = 1'b1;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL %s cmd_ready: got %b want 1", name, cmd_ready);
        end
        hs = cyc;
        if (abort_at < 0) begin
            v = start; err = 1'b0;
            for (int p = 0; p < passes; p++) begin
                v = v + steps[W-1:0] + fault_off;
                if (fault_off != '0) err = 1'b1;
            end
            e.data = v; e.err = err;
            e.lat  = (1 + int'(steps) + RD) * passes + 1 + hold_len;
            sb.push_back(e);
        end

        got = 1'b0; n_en = 0; n_ld = 0; n_oe = 0; both = 0; lat = 0;
        limit = (abort_at >= 0) ? abort_at + 20 : 400;
        for (int k = 1; k <= limit && !got; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            hold  = (hold_len > 0) && (k >= 2 + hold_at) && (k < 2 + hold_at + hold_len);
            abort = (k == abort_at);
            #1;
            if (cnt_en)   n_en++;
            if (cnt_oe)   n_oe++;
            if (cnt_en && cnt_load) both++;
            if (cnt_load) begin
                n_ld++;
                if (n_ld == 1) begin
                    n_cmp++;
                    if (cnt_data !== start) begin
                        n_bad++; $display("FAIL %s cnt_data: got %h want %h", name, cnt_data, start);
                    end
                end
            end
            if (abort_at >= 0 && k == abort_at + 1) begin
                n_cmp++;
                if (busy !== 1'b0 || cmd_ready !== 1'b1 || cnt_en !== 1'b0 ||
                    cnt_oe !== 1'b0 || cnt_load !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s abort_idle: busy=%b ready=%b en=%b oe=%b load=%b want 0 1 0 0 0",
                             name, busy, cmd_ready, cnt_en, cnt_oe, cnt_load);
                end
            end
            if (rsp_valid) begin
                got = 1'b1;
                lat = cyc - hs;
            end
        end
        hold = 1'b0; abort = 1'b0;

        if (abort_at >= 0) begin
            n_cmp++;
            if (got) begin
                n_bad++; $display("FAIL %s rsp_after_abort: got rsp_valid=1 want 0", name);
            end
            n_cmp++;
            if (n_en != 2) begin
                n_bad++; $display("FAIL %s abort_enables: got %0d want 2", name, n_en);
            end
            return;
        end

        n_cmp++;
        if (!got) begin
            n_bad++; $display("FAIL %s timeout: no rsp_valid within %0d cycles", name, limit);
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        if (lat != e.lat) begin
            n_bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
        end
        n_cmp++;
        if (rsp_data !== e.data || rsp_err !== e.err) begin
            n_bad++; $display("FAIL %s rsp: got data=%h err=%b want data=%h err=%b",
                              name, rsp_data, rsp_err, e.data, e.err);
        end
        n_cmp++;
        if (n_en != int'(steps) * passes || n_ld != passes || n_oe != RD * passes || both != 0) begin
            n_bad++; $display("FAIL %s pulses: en=%0d load=%0d oe=%0d both=%0d want %0d %0d %0d 0",
                              name, n_en, n_ld, n_oe, both, int'(steps) * passes, passes, RD * passes);
        end
        // Response must stay put while not consumed.
        @(negedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_err !== e.err) begin
            n_bad++; $display("FAIL %s rsp_hold: valid=%b data=%h err=%b want 1 %h %b",
                              name, rsp_valid, rsp_data, rsp_err, e.data, e.err);
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0; #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL %s rsp_release: valid=%b busy=%b ready=%b want 0 0 1",
                              name, rsp_valid, busy, cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_start = '0; cmd_steps = '0; cmd_repeat_v = '0;
        hold = 1'b0; abort = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || cnt_load !== 1'b0 || cnt_en !== 1'b0 ||
            cnt_oe !== 1'b0 || cnt_data !== '0 || rsp_valid !== 1'b0 || rsp_data !== '0 ||
            rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: ready=%b busy=%b load=%b en=%b oe=%b data=%h rv=%b rd=%h re=%b",
                     cmd_ready, busy, cnt_load, cnt_en, cnt_oe, cnt_data, rsp_valid, rsp_data, rsp_err);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        run_cmd("basic_f0_5", 8'hF0, 16'd5, 4'd0, 0, 0, -1);
    endtask

    task automatic test_wrap();
        run_cmd("wrap_fe_3", 8'hFE, 16'd3, 4'd0, 0, 0, -1);
    endtask

    task automatic test_zero_steps();
        run_cmd("zero_steps", 8'h5A, 16'd0, 4'd0, 0, 0, -1);
    endtask

    task automatic test_hold();
        run_cmd("hold_mid", 8'h20, 16'd4, 4'd0, 2, 3, -1);
    endtask

    task automatic test_abort();
        run_cmd("abort_2nd_en", 8'h40, 16'd5, 4'd0, 0, 0, 3);
    endtask

    task automatic test_back_to_back();
        run_cmd("b2b_a", 8'h33, 16'd1, 4'd0, 0, 0, -1);
        run_cmd("b2b_b", 8'h80, 16'd7, 4'd0, 0, 0, -1);
    endtask

    task automatic test_fault();
        fault_off = 8'd1;
        run_cmd("stuck_plus1", 8'h00, 16'd2, 4'd0, 0, 0, -1);
        fault_off = 8'd0;
    endtask

`ifdef COUNTER_SEQ_REPEAT_EN
    task automatic test_repeat();
        run_cmd("repeat_2", 8'h10, 16'd3, 4'd2, 0, 0, -1);
        fault_off = 8'd1;
        run_cmd("repeat_fault", 8'h00, 16'd2, 4'd1, 0, 0, -1);
        fault_off = 8'd0;
    endtask
`endif

    task automatic test_reset_mid_run();
        @(negedge clk);
        cmd_start = 8'h11; cmd_steps = 16'd10; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (cnt_en !== 1'b1) begin
            n_bad++; $display("FAIL rst_mid_precond: cnt_en=%b want 1", cnt_en);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (cnt_en !== 1'b0 || cnt_load !== 1'b0 || cnt_oe !== 1'b0 || busy !== 1'b0 ||
            cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_run: en=%b load=%b oe=%b busy=%b ready=%b rv=%b want 0 0 0 0 1 0",
                     cnt_en, cnt_load, cnt_oe, busy, cmd_ready, rsp_valid);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_steps();
        test_hold();
        test_abort();
        test_back_to_back();
        test_fault();
`ifdef COUNTER_SEQ_REPEAT_EN
        test_repeat();
`endif
        test_reset_mid_run();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
